// File: rtl/phy_mdio_init_if.sv
// phy_mdio_init_if: MDIO pad bundle between the management master and the board pads.
interface phy_mdio_init_if;
    logic mdc;
    logic mdio_o;
    logic mdio_oe;
    logic mdio_i;
    modport master (output mdc, mdio_o, mdio_oe, input mdio_i);
    modport slave (input mdc, mdio_o, mdio_oe, output mdio_i);
endinterface

// File: rtl/phy_mdio_init.sv
// phy_mdio_init: Clause 22 MDIO master that writes BMCR, then polls BMSR for AN complete + link.
// Define MDIO_WR_VERIFY_EN to read BMCR back after each write (up to 3 writes).
module phy_mdio_init #(
    parameter logic [4:0]  PHY_ADDR   = 5'h00,
    parameter logic [7:0]  MDC_DIV    = 8'd25,
    parameter logic [31:0] SETTLE_CYC = 32'd125000,
    parameter logic [31:0] POLL_GAP   = 32'd1250000,
    parameter logic [15:0] CFG_BMCR   = 16'h1340
) (
    input  logic clk,
    input  logic reset,
    input  logic phy_reset_over,
    output logic init_done,
    output logic autoneg_success,
    phy_mdio_init_if.master mdio
);
    typedef enum logic [2:0] {
        IDLE, SETTLE, WR_BMCR, POLL_WAIT, RD_BMSR
`ifdef MDIO_WR_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    localparam logic [63:0] WR_FR  = {32'hFFFF_FFFF, 4'b0101, PHY_ADDR, 5'd0, 2'b10, CFG_BMCR};
    localparam logic [63:0] RD1_FR = {32'hFFFF_FFFF, 4'b0110, PHY_ADDR, 5'd1, 18'h3FFFF};
    localparam logic [31:0] DIV_M1 = {24'd0, MDC_DIV} - 32'd1;
`ifdef MDIO_WR_VERIFY_EN
    localparam logic [63:0] RD0_FR = {32'hFFFF_FFFF, 4'b0110, PHY_ADDR, 5'd0, 18'h3FFFF};
    localparam int SH_W = 16;
`else
    localparam int SH_W = 6;
`endif

    state_t state_q, state_d, start_st;
    logic [31:0] cnt_q, cnt_d;
    logic [6:0] per_q, per_d;
    logic [SH_W-1:0] sh_q, sh_d;
    logic mdc_q, mdc_d, o_q, o_d, oe_q, oe_d, done_q, done_d, an_q, an_d;
    logic in_frame, tick, step, last, start, to_poll;
    logic [63:0] fr;
`ifdef MDIO_WR_VERIFY_EN
    logic [1:0] wr_q, wr_d;
    logic ok;
    assign in_frame = state_q inside {WR_BMCR, RD_BMSR, VERIFY};
    assign fr = state_q == WR_BMCR ? WR_FR : state_q == RD_BMSR ? RD1_FR : RD0_FR;
    // Bit 9 (restart AN) self-clears in the PHY, so it never reads back as written.
    assign ok = ((sh_q & 16'hFDFF) == (CFG_BMCR & 16'hFDFF)) || wr_q == 2'd3;
`else
    assign in_frame = state_q inside {WR_BMCR, RD_BMSR};
    assign fr = state_q == WR_BMCR ? WR_FR : RD1_FR;
`endif
    assign tick = cnt_q == DIV_M1;
    // First clk after an MDC fall: time to present the next bit, or to close the frame.
    assign step = !mdc_q && cnt_q == 32'd0;
    assign last = per_q == 7'd64;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        mdc_d    = mdc_q;
        o_d      = o_q;
        oe_d     = oe_q;
        sh_d     = sh_q;
        done_d   = done_q;
        an_d     = an_q;
        start    = 1'b0;
        to_poll  = 1'b0;
        start_st = WR_BMCR;
`ifdef MDIO_WR_VERIFY_EN
        wr_d     = wr_q;
`endif
        if (in_frame) begin
            cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
            mdc_d = tick ? !mdc_q : mdc_q;
            per_d = (tick && mdc_q) ? per_q + 7'd1 : per_q;
            sh_d  = (tick && !mdc_q) ? {sh_q[SH_W-2:0], mdio.mdio_i} : sh_q;
            o_d   = (step && !last) ? fr[6'd63 - per_q[5:0]] : o_q;
            oe_d  = (step && !last) ? (state_q == WR_BMCR || per_q < 7'd46) : oe_q;
        end
        case (state_q)
            IDLE:      state_d = phy_reset_over ? SETTLE : IDLE;
            SETTLE:    begin
                start = cnt_q == SETTLE_CYC - 32'd1;
                cnt_d = cnt_q + 32'd1;
            end
            POLL_WAIT: begin
                start    = cnt_q == POLL_GAP - 32'd1;
                start_st = RD_BMSR;
                cnt_d    = cnt_q + 32'd1;
            end
`ifdef MDIO_WR_VERIFY_EN
            WR_BMCR:   if (step && last) begin
                start    = 1'b1;
                start_st = VERIFY;
                wr_d     = wr_q + 2'd1;
            end
            VERIFY:    if (step && last) begin
                done_d  = done_q | ok;
                to_poll = ok;
                start   = !ok;
            end
`else
            WR_BMCR:   if (step && last) begin
                done_d  = 1'b1;
                to_poll = 1'b1;
            end
`endif
            RD_BMSR:   if (step && last) begin
                an_d    = sh_q[5] & sh_q[2];
                to_poll = 1'b1;
            end
            default:   state_d = IDLE;
        endcase
        if (to_poll) begin
            state_d = POLL_WAIT;
            cnt_d   = '0;
            per_d   = '0;
            oe_d    = 1'b0;
            o_d     = 1'b1;
        end
        // Frame start behaves like the clk after a virtual MDC fall, so the low half is already 1 clk old.
        if (start) begin
            state_d = start_st;
            cnt_d   = 32'd1;
            per_d   = '0;
            mdc_d   = 1'b0;
            oe_d    = 1'b1;
            o_d     = 1'b1;
        end
        if (!phy_reset_over) begin
            state_d = IDLE;
            cnt_d   = '0;
            per_d   = '0;
            sh_d    = '0;
            mdc_d   = 1'b0;
            o_d     = 1'b1;
            oe_d    = 1'b0;
            done_d  = 1'b0;
            an_d    = 1'b0;
`ifdef MDIO_WR_VERIFY_EN
            wr_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            sh_q    <= '0;
            mdc_q   <= 1'b0;
            o_q     <= 1'b1;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            an_q    <= 1'b0;
`ifdef MDIO_WR_VERIFY_EN
            wr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            sh_q    <= sh_d;
            mdc_q   <= mdc_d;
            o_q     <= o_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            an_q    <= an_d;
`ifdef MDIO_WR_VERIFY_EN
            wr_q    <= wr_d;
`endif
        end
    end

    assign init_done       = done_q;
    assign autoneg_success = an_q;
    assign mdio.mdc        = mdc_q;
    assign mdio.mdio_o     = o_q;
    assign mdio.mdio_oe    = oe_q;
endmodule

// File: tb/tb_phy_mdio_init.sv
// tb_phy_mdio_init: directed checks of frame timing/content, BMSR polling, abort and async reset,
// with a small PHY model answering read frames.
`timescale 1ns/1ps
module tb_phy_mdio_init;
    localparam logic [63:0] WR_FR  = {32'hFFFF_FFFF, 4'b0101, 5'h03, 5'h00, 2'b10, 16'h1340};
    localparam logic [45:0] RD1_HI = {32'hFFFF_FFFF, 4'b0110, 5'h03, 5'h01};
    localparam logic [63:0] RD_OE  = {{46{1'b1}}, 18'h0};
`ifdef MDIO_WR_VERIFY_EN
    localparam int DONE_LAT = 512;
    localparam logic [63:0] DONE_FR   = {32'hFFFF_FFFF, 4'b0110, 5'h03, 5'h00, 18'h0};
    localparam logic [63:0] DONE_MASK = RD_OE;
    localparam logic [63:0] DONE_OE   = RD_OE;
`else
    localparam int DONE_LAT = 256;
    localparam logic [63:0] DONE_FR   = WR_FR;
    localparam logic [63:0] DONE_MASK = '1;
    localparam logic [63:0] DONE_OE   = '1;
`endif

    logic clk = 1'b0, reset = 1'b0, por = 1'b0;
    logic init_done, autoneg_success;
    int total = 0, bad = 0, cyc = 0;
    logic [15:0] bmsr_val = 16'h7829, bmcr_val = 16'h1140, rdval = '1;
    logic [63:0] cap = '0, oecap = '0;
    logic [5:0] pidx = '0;

    phy_mdio_init_if m();
    phy_mdio_init #(
        .PHY_ADDR(5'h03), .MDC_DIV(8'd2), .SETTLE_CYC(32'd10), .POLL_GAP(32'd100), .CFG_BMCR(16'h1340)
    ) dut (
        .clk(clk), .reset(reset), .phy_reset_over(por),
        .init_done(init_done), .autoneg_success(autoneg_success), .mdio(m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PHY side: capture each bit on MDC rise, present read data after MDC fall.
    always @(posedge m.mdc or negedge por or negedge reset)
        if (!por || !reset) pidx <= '0;
        else begin
            cap   <= {cap[62:0], m.mdio_o};
            oecap <= {oecap[62:0], m.mdio_oe};
            pidx  <= pidx + 6'd1;
        end
    always @(negedge m.mdc) begin
        if (pidx == 6'd46) rdval = (cap[4:0] == 5'd0) ? bmcr_val : bmsr_val;
        m.mdio_i = (pidx >= 6'd48) ? rdval[6'd63 - pidx] : 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_oe(input string tag, output int t);
        int n = 0;
        while (!m.mdio_oe && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_oe_seen"}, 64'(m.mdio_oe), 64'd1);
        t = cyc;
    endtask

    task automatic wait_done(input string tag, output int t);
        int n = 0;
        while (!init_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(init_done), 64'd1);
        t = cyc;
    endtask

    initial begin
        int c0, f0, t, rs;
        @(negedge clk);
        chk("rst_done", 64'(init_done), 64'd0);
        chk("rst_an", 64'(autoneg_success), 64'd0);
        chk("rst_mdc", 64'(m.mdc), 64'd0);
        chk("rst_o", 64'(m.mdio_o), 64'd1);
        chk("rst_oe", 64'(m.mdio_oe), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_oe", 64'(m.mdio_oe), 64'd0);

        por = 1'b1;
        c0 = cyc;
        wait_oe("wr", f0);
        chk("wr_start", 64'(f0 - c0), 64'd11);
        chk("wr_mdc_lo", 64'(m.mdc), 64'd0);
        @(negedge clk);
        chk("wr_mdc_rise", 64'(m.mdc), 64'd1);
        wait_done("wr", t);
        chk("done_lat", 64'(t - f0), 64'(DONE_LAT));
        chk("wr_frame", cap & DONE_MASK, DONE_FR & DONE_MASK);
        chk("wr_oe", oecap, DONE_OE);

        wait_oe("rd1", rs);
        chk("rd1_gap", 64'(rs - t), 64'd100);
        repeat (255) @(negedge clk);
        chk("rd1_an", 64'(autoneg_success), 64'd0);
        chk("rd1_hdr", 64'(cap[63:18]), 64'(RD1_HI));
        chk("rd1_oe", oecap, RD_OE);
        bmsr_val = 16'h782D;
        @(negedge clk);
        chk("rd1_end_oe", 64'(m.mdio_oe), 64'd0);
        t = cyc;
        wait_oe("rd2", rs);
        chk("rd2_gap", 64'(rs - t), 64'd100);
        repeat (255) @(negedge clk);
        chk("rd2_an_hold", 64'(autoneg_success), 64'd0);
        @(negedge clk);
        chk("rd2_an_set", 64'(autoneg_success), 64'd1);

        wait_oe("rd3", rs);
        repeat (161) @(negedge clk);
        chk("ab_pre_mdc", 64'(m.mdc), 64'd1);
        chk("ab_pre_oe", 64'(m.mdio_oe), 64'd1);
        por = 1'b0;
        @(negedge clk);
        chk("ab_mdc", 64'(m.mdc), 64'd0);
        chk("ab_oe", 64'(m.mdio_oe), 64'd0);
        chk("ab_o", 64'(m.mdio_o), 64'd1);
        chk("ab_done", 64'(init_done), 64'd0);
        chk("ab_an", 64'(autoneg_success), 64'd0);
        repeat (20) @(negedge clk);
        chk("ab_stay", 64'(m.mdc | m.mdio_oe), 64'd0);

        por = 1'b1;
        c0 = cyc;
        wait_oe("re", f0);
        chk("re_start", 64'(f0 - c0), 64'd11);
        wait_done("re", t);
        chk("re_lat", 64'(t - f0), 64'(DONE_LAT));
        chk("re_frame", cap & DONE_MASK, DONE_FR & DONE_MASK);

        por = 1'b0;
        @(negedge clk);
        por = 1'b1;
        wait_oe("ar", f0);
        repeat (98) @(negedge clk);
        chk("ar_pre_mdc", 64'(m.mdc), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_mdc", 64'(m.mdc), 64'd0);
        chk("ar_oe", 64'(m.mdio_oe), 64'd0);
        chk("ar_o", 64'(m.mdio_o), 64'd1);
        chk("ar_done", 64'(init_done), 64'd0);
        @(negedge clk);
`ifdef MDIO_WR_VERIFY_EN
        bmcr_val = 16'h0000;
        reset = 1'b1;
        wait_oe("vf", f0);
        wait_done("vf", t);
        chk("vf_lat", 64'(t - f0), 64'd1536);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
